// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues word fetches with credit-based
// flow control, and buffers returned instructions with their PCs for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  input  logic        if_id_ready,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [0:0]  state_dbg
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;
  localparam logic [0:0]     ST_RESET = 1'b0;
  localparam logic [0:0]     ST_RUN   = 1'b1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, fifo_count, live;
  logic [CW:0]   credit_sum;
  logic [PW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   tag_mem  [FIFO_DEPTH];
  logic          accept, push, pop, drop, fifo_empty, fifo_full;

  // Handshakes: a transfer happens on a rising edge where valid && ready; requests may
  // be withdrawn by a redirect before acceptance, everything else holds until taken.
  assign live       = outstanding - drop_cnt;
  assign credit_sum = {1'b0, fifo_count} + {1'b0, live};
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);

  assign imem_req_valid = (state == ST_RUN) && (outstanding < DEPTH_C) &&
                          (credit_sum < {1'b0, DEPTH_C}) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop = imem_rsp_valid && (drop_cnt != '0);
  assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign if_id_valid       = !fifo_empty && !redirect_valid;
  assign pop               = if_id_valid && if_id_ready;
  assign if_id_instruction = fifo_empty ? NOP   : data_mem[rd_ptr];
  assign if_id_pc          = fifo_empty ? 32'h0 : pc_mem[rd_ptr];

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);
  assign state_dbg        = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RESET;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      state       <= ST_RUN;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the wrong path.
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        drop_cnt   <= outstanding_next;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        tag_rd     <= tag_wr;
      end else begin
        if (accept) begin
          pc     <= pc + 32'd4;
          tag_wr <= tag_wr + PW'(1);
        end
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          tag_rd <= tag_rd + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= pc;
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= tag_mem[tag_rd];
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory responder with programmable latency,
// returning addr ^ 32'hA5A5_0000 as the instruction word.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic        if_id_ready;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [0:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int mem_lat = 1;
  int cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of directed sequence");
    $fatal(1);
  end

  // Memory responder: records accepts at mid-cycle, answers in order after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n && imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!reset_n) begin
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
      end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq_addr[0] ^ 32'hA5A5_0000;
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rr, input logic ir, input int lat);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = rr;
    if_id_ready    = ir;
    mem_lat        = lat;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_id_ready    = 1'b0;

    // 1: streaming with single-cycle memory
    do_reset(1'b1, 1'b1, 1);
    mid();
    check("t1_rst_req_valid", imem_req_valid, 32'd0);
    check("t1_rst_req_addr", imem_req_addr, 32'h0);
    check("t1_rst_if_id_valid", if_id_valid, 32'd0);
    check("t1_rst_instr_nop", if_id_instruction, 32'h0000_0013);
    check("t1_rst_if_id_pc", if_id_pc, 32'h0);
    check("t1_rst_state", state_dbg, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      mid();
      if (i == 1) check("t1_state_run", state_dbg, 32'd1);
      if (i <= 4) begin
        check("t1_req_valid", imem_req_valid, 32'd1);
        check("t1_req_addr", imem_req_addr, 32'(4 * (i - 1)));
      end
      if (i >= 3) begin
        check("t1_if_id_valid", if_id_valid, 32'd1);
        check("t1_if_id_pc", if_id_pc, 32'(4 * (i - 3)));
        check("t1_if_id_instr", if_id_instruction, 32'(4 * (i - 3)) ^ 32'hA5A5_0000);
      end
    end

    // 2: decode stalled, credit limit, single pop frees one request
    do_reset(1'b1, 1'b0, 1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      mid();
      check("t2_req_addr", imem_req_addr, 32'(4 * (i - 1)));
      check("t2_req_valid", imem_req_valid, 32'd1);
    end
    next_cycle(); mid();
    check("t2_req_blocked_c5", imem_req_valid, 32'd0);
    next_cycle(); mid();
    check("t2_req_blocked_c6", imem_req_valid, 32'd0);
    check("t2_head_valid", if_id_valid, 32'd1);
    check("t2_head_pc", if_id_pc, 32'h0);
    next_cycle(); if_id_ready = 1'b1; mid();
    check("t2_pop_pc", if_id_pc, 32'h0);
    check("t2_req_blocked_c7", imem_req_valid, 32'd0);
    next_cycle(); if_id_ready = 1'b0; mid();
    check("t2_one_req_valid", imem_req_valid, 32'd1);
    check("t2_one_req_addr", imem_req_addr, 32'h10);
    check("t2_head_after_pop", if_id_pc, 32'h4);
    next_cycle(); mid();
    check("t2_req_blocked_c9", imem_req_valid, 32'd0);
    next_cycle(); if_id_ready = 1'b1; mid();
    check("t2_req_blocked_c10", imem_req_valid, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_pc", if_id_pc, 32'(4 + 4 * i));
      check("t2_drain_instr", if_id_instruction, 32'(4 + 4 * i) ^ 32'hA5A5_0000);
      next_cycle(); mid();
    end

    // 3: redirect with two late responses in flight
    do_reset(1'b1, 1'b1, 1);
    next_cycle(); next_cycle();
    next_cycle(); imem_req_ready = 1'b0; mem_lat = 3; mid();
    check("t3_req_addr_c3", imem_req_addr, 32'h8);
    check("t3_head_pc_c3", if_id_pc, 32'h0);
    next_cycle(); imem_req_ready = 1'b1; mid();
    check("t3_req_addr_c4", imem_req_addr, 32'h8);
    check("t3_head_pc_c4", if_id_pc, 32'h4);
    next_cycle(); mid();
    check("t3_req_addr_c5", imem_req_addr, 32'hC);
    next_cycle(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; mid();
    check("t3_redirect_no_req", imem_req_valid, 32'd0);
    check("t3_redirect_no_valid", if_id_valid, 32'd0);
    next_cycle(); redirect_valid = 1'b0; imem_req_ready = 1'b1; mid();
    check("t3_new_req_valid", imem_req_valid, 32'd1);
    check("t3_new_req_addr", imem_req_addr, 32'h100);
    check("t3_stale_c7", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t3_req_addr_c8", imem_req_addr, 32'h104);
    check("t3_stale_c8", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t3_stale_c9", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t3_stale_c10", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t3_first_valid", if_id_valid, 32'd1);
    check("t3_first_pc", if_id_pc, 32'h100);
    check("t3_first_instr", if_id_instruction, 32'hA5A5_0100);

    // 4: misaligned redirect coinciding with a response and a stalled request
    do_reset(1'b1, 1'b1, 2);
    next_cycle();
    next_cycle(); imem_req_ready = 1'b0; mid();
    check("t4_pending_valid", imem_req_valid, 32'd1);
    check("t4_pending_addr", imem_req_addr, 32'h4);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h103; mid();
    check("t4_withdrawn", imem_req_valid, 32'd0);
    check("t4_redirect_no_valid", if_id_valid, 32'd0);
    next_cycle(); redirect_valid = 1'b0; imem_req_ready = 1'b1; mid();
    check("t4_aligned_valid", imem_req_valid, 32'd1);
    check("t4_aligned_addr", imem_req_addr, 32'h100);
    check("t4_rsp_dropped", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t4_req_addr_c5", imem_req_addr, 32'h104);
    next_cycle(); mid();
    check("t4_empty_c6", if_id_valid, 32'd0);
    next_cycle(); mid();
    check("t4_first_valid", if_id_valid, 32'd1);
    check("t4_first_pc", if_id_pc, 32'h100);
    check("t4_first_instr", if_id_instruction, 32'hA5A5_0100);

    // 5: address held while stalled; PC wraps at the top of the address space
    do_reset(1'b0, 1'b1, 1);
    next_cycle(); mid();
    check("t5_reset_addr", imem_req_addr, 32'h0);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); redirect_valid = 1'b0; mid();
      check("t5_hold_valid", imem_req_valid, 32'd1);
      check("t5_hold_addr", imem_req_addr, 32'h40);
    end
    next_cycle(); imem_req_ready = 1'b1; mid();
    check("t5_accept_addr", imem_req_addr, 32'h40);
    next_cycle(); imem_req_ready = 1'b0; mid();
    check("t5_next_addr", imem_req_addr, 32'h44);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; mid();
    check("t5_redirect_masks_valid", if_id_valid, 32'd0);
    next_cycle(); redirect_valid = 1'b0; imem_req_ready = 1'b1; mid();
    check("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("t5_flushed", if_id_valid, 32'd0);
    next_cycle(); imem_req_ready = 1'b0; mid();
    check("t5_wrap_valid", imem_req_valid, 32'd1);
    check("t5_wrap_addr", imem_req_addr, 32'h0);
    next_cycle(); mid();
    check("t5_top_pc", if_id_pc, 32'hFFFF_FFFC);
    check("t5_top_instr", if_id_instruction, 32'h5A5A_FFFC);

    // 6: asynchronous reset with three entries buffered
    do_reset(1'b1, 1'b0, 1);
    next_cycle(); next_cycle(); next_cycle();
    next_cycle(); imem_req_ready = 1'b0;
    next_cycle(); mid();
    check("t6_pre_valid", if_id_valid, 32'd1);
    check("t6_pre_pc", if_id_pc, 32'h0);
    check("t6_pre_req_addr", imem_req_addr, 32'hC);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_if_id_valid", if_id_valid, 32'd0);
    check("t6_async_req_valid", imem_req_valid, 32'd0);
    check("t6_async_instr", if_id_instruction, 32'h0000_0013);
    check("t6_async_addr", imem_req_addr, 32'h0);
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1; imem_req_ready = 1'b1;
    mid();
    check("t6_release_no_req", imem_req_valid, 32'd0);
    next_cycle(); mid();
    check("t6_first_req_valid", imem_req_valid, 32'd1);
    check("t6_first_req_addr", imem_req_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
